// File: rtl/fft_pkg.sv
// Shared FFT constants, stream FSM states and the packed-bus bin-slice helper.
package fft_pkg;

  localparam int unsigned FFT_N     = 16;
  localparam int unsigned FFT_WIDTH = 16;
  localparam int unsigned FFT_IDX_W = $clog2(FFT_N);

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } stream_state_e;

  // Bin k of a packed bus lives at [FFT_WIDTH*k +: FFT_WIDTH].
  function automatic logic signed [FFT_WIDTH-1:0] fft_bin(
    input logic [FFT_WIDTH*FFT_N-1:0] i_bus,
    input logic [FFT_IDX_W-1:0]       i_k
  );
    return i_bus[FFT_WIDTH*i_k +: FFT_WIDTH];
  endfunction

endpackage

// File: rtl/fft_abs_sum.sv
// Combinational |a|+|b| for signed inputs; abs is taken as unsigned WIDTH bits so the
// most negative value maps to 2^(WIDTH-1) and the WIDTH+1 bit sum cannot overflow.
module fft_abs_sum #(
  parameter int unsigned WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic        [WIDTH:0]   o_sum
);

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  assign w_abs_a = i_a[WIDTH-1] ? (~unsigned'(i_a) + 1'b1) : unsigned'(i_a);
  assign w_abs_b = i_b[WIDTH-1] ? (~unsigned'(i_b) + 1'b1) : unsigned'(i_b);
  assign o_sum   = {1'b0, w_abs_a} + {1'b0, w_abs_b};

endmodule

// File: rtl/fft_result_streamer.sv
// Snapshots a parallel FFT result on fft_done and streams one bin per valid/ready beat,
// flagging frames that arrive while a stream is still in progress.
module fft_result_streamer
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH  = FFT_WIDTH,
  parameter int unsigned N_BINS = FFT_N,
  localparam int unsigned IDX_W = $clog2(N_BINS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fft_done,
  input  logic [WIDTH*N_BINS-1:0]   fft_real_in,
  input  logic [WIDTH*N_BINS-1:0]   fft_imag_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          out_index,
  output logic signed [WIDTH-1:0]   out_real,
  output logic signed [WIDTH-1:0]   out_imag,
  output logic [WIDTH:0]            out_mag,
  output logic                      out_last,
  output logic                      busy,
  output logic                      overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);

  stream_state_e           r_state;
  stream_state_e           w_state_d;
  logic [IDX_W-1:0]        r_index;
  logic [IDX_W-1:0]        w_index_d;
  logic                    r_overrun;
  logic                    w_overrun_d;
  logic                    w_capture;
  logic                    w_accept;
  logic                    w_at_last;
  logic signed [WIDTH-1:0] r_snap_re [N_BINS];
  logic signed [WIDTH-1:0] r_snap_im [N_BINS];

  assign w_accept  = (r_state == StStream) && out_ready;
  assign w_at_last = (r_index == LAST_IDX);

  always_comb begin
    w_state_d   = r_state;
    w_index_d   = r_index;
    w_overrun_d = r_overrun;
    w_capture   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (fft_done) begin
          w_capture = 1'b1;
          w_index_d = '0;
          w_state_d = StStream;
        end
      end
      StStream: begin
        if (w_accept && w_at_last) begin
          // A frame landing on the final handshake chains straight into the next stream.
          if (fft_done) begin
            w_capture = 1'b1;
            w_index_d = '0;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          if (w_accept) w_index_d = r_index + 1'b1;
          if (fft_done) w_overrun_d = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_index   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_index   <= w_index_d;
      r_overrun <= w_overrun_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_BINS; k++) begin
        r_snap_re[k] <= '0;
        r_snap_im[k] <= '0;
      end
    end else if (w_capture) begin
      for (int k = 0; k < N_BINS; k++) begin
        r_snap_re[k] <= fft_real_in[WIDTH*k +: WIDTH];
        r_snap_im[k] <= fft_imag_in[WIDTH*k +: WIDTH];
      end
    end
  end

  assign out_valid = (r_state == StStream);
  assign busy      = (r_state == StStream);
  assign out_index = r_index;
  assign out_real  = r_snap_re[r_index];
  assign out_imag  = r_snap_im[r_index];
  assign out_last  = out_valid && w_at_last;
  assign overrun   = r_overrun;

  fft_abs_sum #(
    .WIDTH(WIDTH)
  ) u_abs_sum (
    .i_a  (out_real),
    .i_b  (out_imag),
    .o_sum(out_mag)
  );

endmodule

// File: tb/tb_fft_result_streamer.sv
// Bench for fft_result_streamer: frame-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_fft_result_streamer;

  localparam int W = 16;
  localparam int N = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                fft_done = 1'b0;
  logic [W*N-1:0]      fft_real_in = '0;
  logic [W*N-1:0]      fft_imag_in = '0;
  logic                out_ready = 1'b0;
  logic                out_valid;
  logic [3:0]          out_index;
  logic signed [W-1:0] out_real;
  logic signed [W-1:0] out_imag;
  logic [W:0]          out_mag;
  logic                out_last;
  logic                busy;
  logic                overrun;

  int checks = 0;
  int errors = 0;
  int fr_re[N];
  int fr_im[N];

  // Reference model: the frame being streamed and the position within it.
  bit m_busy = 1'b0;
  bit m_ovr = 1'b0;
  int m_pos = 0;
  int m_re[N];
  int m_im[N];
  bit m_acc_last;

  fft_result_streamer #(
    .WIDTH (W),
    .N_BINS(N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fft_done   (fft_done),
    .fft_real_in(fft_real_in),
    .fft_imag_in(fft_imag_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_real   (out_real),
    .out_imag   (out_imag),
    .out_mag    (out_mag),
    .out_last   (out_last),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  assign m_acc_last = m_busy && out_ready && (m_pos == N - 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_ovr  <= 1'b0;
      m_pos  <= 0;
    end else begin
      if (m_busy && fft_done && !m_acc_last) m_ovr <= 1'b1;
      if (fft_done && (!m_busy || m_acc_last)) begin
        for (int k = 0; k < N; k++) begin
          m_re[k] <= int'($signed(fft_real_in[W*k +: W]));
          m_im[k] <= int'($signed(fft_imag_in[W*k +: W]));
        end
        m_pos  <= 0;
        m_busy <= 1'b1;
      end else if (m_busy && out_ready) begin
        if (m_acc_last) m_busy <= 1'b0;
        else            m_pos  <= m_pos + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_index", out_index, 0);
      check("rst_real", out_real, 0);
      check("rst_imag", out_imag, 0);
      check("rst_mag", out_mag, 0);
      check("rst_last", out_last, 0);
    end else begin
      check("valid", out_valid, m_busy);
      check("busy", busy, m_busy);
      check("overrun", overrun, m_ovr);
      if (m_busy) begin
        check("index", out_index, m_pos);
        check("real", out_real, m_re[m_pos]);
        check("imag", out_imag, m_im[m_pos]);
        check("mag", out_mag, iabs(m_re[m_pos]) + iabs(m_im[m_pos]));
        check("last", out_last, m_pos == N - 1);
      end else begin
        check("last_idle", out_last, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Presents fr_re/fr_im for one edge with fft_done, then scrambles the buses.
  task automatic pulse();
    for (int k = 0; k < N; k++) begin
      fft_real_in[W*k +: W] = 16'(fr_re[k]);
      fft_imag_in[W*k +: W] = 16'(fr_im[k]);
    end
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    for (int j = 0; j < N / 2; j++) begin
      fft_real_in[32*j +: 32] = $urandom();
      fft_imag_in[32*j +: 32] = $urandom();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 100) begin
      step();
      n++;
    end
    check("drain_timeout", out_valid, 0);
  endtask

  initial begin
    int k;
    int cyc;
    #1 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Impulse, ready always high.
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 32767;
      fr_im[i] = 0;
    end
    out_ready = 1'b1;
    pulse();
    for (int i = 0; i < N; i++) begin
      check("t1_index", out_index, i);
      check("t1_last", out_last, i == N - 1);
      check("t1_mag", out_mag, 32767);
      step();
    end
    check("t1_valid_after", out_valid, 0);

    // Backpressure: ready high one cycle in three.
    for (int i = 0; i < N; i++) begin
      fr_re[i] = i;
      fr_im[i] = -i;
    end
    out_ready = 1'b0;
    pulse();
    k = 0;
    cyc = 0;
    while (k < N && cyc < 100) begin
      out_ready = (cyc % 3 == 2);
      if (out_ready) begin
        check("t2_index", out_index, k);
        check("t2_mag", out_mag, 2 * k);
        k++;
      end
      step();
      cyc++;
    end
    check("t2_beats", k, N);
    check("t2_valid_after", out_valid, 0);

    // Back-to-back frame on the final handshake.
    for (int i = 0; i < N; i++) begin
      fr_re[i] = i;
      fr_im[i] = 1;
    end
    out_ready = 1'b1;
    pulse();
    repeat (15) step();
    check("t4_pre_index", out_index, 15);
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 1000 + i;
      fr_im[i] = -2;
    end
    pulse();
    check("t4_valid", out_valid, 1);
    check("t4_index", out_index, 0);
    check("t4_real", out_real, 1000);
    check("t4_imag", out_imag, -2);
    check("t4_overrun", overrun, 0);
    drain();

    // Magnitude extremes.
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 0;
      fr_im[i] = 0;
    end
    fr_re[3] = -32768;
    fr_im[3] = -32768;
    fr_re[4] = 32767;
    fr_im[4] = -32768;
    pulse();
    repeat (3) step();
    check("t5_index3", out_index, 3);
    check("t5_mag3", out_mag, 65536);
    step();
    check("t5_index4", out_index, 4);
    check("t5_mag4", out_mag, 65535);
    drain();

    // Overrun: second frame arrives mid-stream and must be dropped.
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 100 + i;
      fr_im[i] = i;
    end
    pulse();
    repeat (5) step();
    check("t3_index5", out_index, 5);
    for (int i = 0; i < N; i++) begin
      fr_re[i] = -7 - i;
      fr_im[i] = 55;
    end
    pulse();
    check("t3_overrun", overrun, 1);
    check("t3_index6", out_index, 6);
    check("t3_real6", out_real, 106);
    check("t3_imag6", out_imag, 6);
    drain();
    check("t3_overrun_sticky", overrun, 1);

    // Reset mid-stream.
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 3 * i;
      fr_im[i] = -i;
    end
    pulse();
    repeat (7) step();
    check("t6_index7", out_index, 7);
    #1 rst_n = 1'b0;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_overrun", overrun, 0);
    check("t6_index", out_index, 0);
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 200 + i;
      fr_im[i] = 9;
    end
    pulse();
    check("t6_restart_valid", out_valid, 1);
    check("t6_restart_index", out_index, 0);
    check("t6_restart_real", out_real, 200);
    check("t6_restart_overrun", overrun, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
